// File: rtl/ofmap_pack64_if.sv
// Result-word input and OUTPUT_STREAM_if write-side signals of the DLA64 output packer.
// The slave modport is the packer's view; the master modport is the surrounding logic's view.
interface ofmap_pack64_if #(
  parameter int TBITS = 64,
  parameter int IBITS = TBITS / 2
);
  localparam int TBYTE = TBITS / 8;

  logic             res_valid;
  logic             res_ready;
  logic [IBITS-1:0] res_data;
  logic             osif_full_n;
  logic             osif_write;
  logic [TBITS-1:0] osif_data_din;
  logic [TBYTE-1:0] osif_strb_din;
  logic             osif_last_din;
  logic             osif_user_din;

  modport slave (
    input  res_valid, res_data, osif_full_n,
    output res_ready, osif_write, osif_data_din, osif_strb_din, osif_last_din, osif_user_din
  );

  modport master (
    output res_valid, res_data, osif_full_n,
    input  res_ready, osif_write, osif_data_din, osif_strb_din, osif_last_din, osif_user_din
  );
endinterface

// File: rtl/ofmap_pack64.sv
// Packs 32-bit result words two-per-beat into 64-bit OUTPUT_STREAM_if beats,
// with a two-entry beat FIFO absorbing downstream back-pressure.
module ofmap_pack64 #(
  parameter int TBITS = 64,
  parameter int TBYTE = TBITS / 8,
  parameter int IBITS = TBITS / 2,
  parameter int LEN_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_words,
  output logic             busy,
  output logic             done,
  ofmap_pack64_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] rem_cnt;
  logic             half;
  logic [IBITS-1:0] hold;

  logic [TBITS-1:0] fifo_data [2];
  logic [TBYTE-1:0] fifo_strb [2];
  logic             fifo_last [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_cnt;

  logic             accept;
  logic             final_word;
  logic             push;
  logic             pop;
  logic [TBITS-1:0] push_data;
  logic [TBYTE-1:0] push_strb;

  assign busy       = (state == RUN) || (state == FLUSH);
  assign done       = (state == DONE);
  assign bus.res_ready = (state == RUN) && (fifo_cnt < 2'd2);
  assign accept     = bus.res_valid && bus.res_ready;
  assign final_word = (rem_cnt == LEN_W'(1));

  // A beat is formed on the second word of a pair, or on a lone final word.
  assign push = accept && (half || final_word);
  assign pop  = bus.osif_write;

  always_comb begin
    push_data = {bus.res_data, hold};
    push_strb = {TBYTE{1'b1}};
    if (!half) begin
      push_data = {{(TBITS-IBITS){1'b0}}, bus.res_data};
      push_strb = {{(TBYTE/2){1'b0}}, {(TBYTE/2){1'b1}}};
    end
  end

  assign bus.osif_write    = (fifo_cnt != 2'd0) && bus.osif_full_n;
  assign bus.osif_data_din = (fifo_cnt != 2'd0) ? fifo_data[rd_ptr] : '0;
  assign bus.osif_strb_din = (fifo_cnt != 2'd0) ? fifo_strb[rd_ptr] : '0;
  assign bus.osif_last_din = (fifo_cnt != 2'd0) && fifo_last[rd_ptr];
  assign bus.osif_user_din = 1'b0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      rem_cnt  <= '0;
      half     <= 1'b0;
      hold     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem_cnt <= cfg_words;
            half    <= 1'b0;
            state   <= (cfg_words == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            rem_cnt <= rem_cnt - LEN_W'(1);
            if (final_word) begin
              half  <= 1'b0;
              state <= FLUSH;
            end else if (!half) begin
              hold <= bus.res_data;
              half <= 1'b1;
            end else begin
              half <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (fifo_cnt == 2'd0) state <= DONE;
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Beat storage needs no reset: entries are only observed while fifo_cnt covers them.
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_strb[wr_ptr] <= push_strb;
      fifo_last[wr_ptr] <= final_word;
    end
  end

endmodule

// File: tb/tb_ofmap_pack64.sv
// Self-checking bench for ofmap_pack64: randomized frames compared against a
// word-list-to-beat reference model, plus reset, zero-length, stall and restart scenarios.
module tb_ofmap_pack64;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_words = '0;
  logic        busy;
  logic        done;

  ofmap_pack64_if bus ();

  ofmap_pack64 dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .cfg_words (cfg_words),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int first_acc_cyc = 0;
  int last_acc_cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic [31:0] words [$];
  beat_t obs [$];
  beat_t exp_q [$];

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (bus.osif_write) begin
      obs.push_back('{d: bus.osif_data_din, s: bus.osif_strb_din, l: bus.osif_last_din});
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.res_valid && bus.res_ready) begin
      if (acc_cnt == 0) first_acc_cyc = cyc;
      acc_cnt++;
      last_acc_cyc = cyc;
    end
  end

  task automatic clear_obs();
    obs.delete();
    done_cnt = 0;
    acc_cnt = 0;
  endtask

  // Reference: words pair up low-first; an odd final word gets a half strobe.
  task automatic build_expected(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n)
        exp_q.push_back('{d: {words[i+1], words[i]}, s: 8'hFF, l: (i + 2 == n)});
      else
        exp_q.push_back('{d: {32'h0, words[i]}, s: 8'h0F, l: 1'b1});
    end
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic check_beats(input string tag);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s beat_count: got %0d expected %0d", tag, obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i].d !== exp_q[i].d || obs[i].s !== exp_q[i].s || obs[i].l !== exp_q[i].l) begin
        n_err++;
        $display("FAIL %s beat%0d: got %h/%h/%b expected %h/%h/%b", tag, i,
                 obs[i].d, obs[i].s, obs[i].l, exp_q[i].d, exp_q[i].s, exp_q[i].l);
      end
    end
  endtask

  // Drives one frame of n words from the words queue and checks the result.
  task automatic run_frame(input string tag, input int n, input int stall,
                           input bit rnd, input bit restart);
    bit finished = 0;
    clear_obs();
    build_expected(n);
    @(posedge aclk); #1;
    start = 1'b1;
    cfg_words = 16'(n);
    for (int it = 0; it < 3000 && !finished; it++) begin
      @(posedge aclk); #1;
      if (done_cnt != 0) begin
        finished = 1;
      end else begin
        start = (restart && it == 3);
        if (restart && it == 3) cfg_words = 16'd2;
        bus.osif_full_n = (it < stall) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        bus.res_valid = (acc_cnt < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        bus.res_data = (acc_cnt < n) ? words[acc_cnt] : 32'h0;
        if (stall > 0 && it == stall - 1) begin
          n_cmp++;
          if (bus.res_ready !== 1'b0 || acc_cnt < 4 || acc_cnt > 5 || obs.size() != 0) begin
            n_err++;
            $display("FAIL %s stall_state: ready=%b accepted=%0d writes=%0d required ready=0 accepted 4..5 writes=0",
                     tag, bus.res_ready, acc_cnt, obs.size());
          end
        end
      end
    end
    start = 1'b0;
    bus.res_valid = 1'b0;
    bus.osif_full_n = 1'b1;
    n_cmp++;
    if (!finished) begin
      n_err++;
      $display("FAIL %s timeout: no done pulse within budget", tag);
    end
    repeat (3) @(posedge aclk);
    #1;
    check_beats(tag);
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt);
    end
    n_cmp++;
    if (acc_cnt != n) begin
      n_err++;
      $display("FAIL %s accepted: got %0d expected %0d", tag, acc_cnt, n);
    end
    n_cmp++;
    if (done_cyc - last_wr_cyc != 2) begin
      n_err++;
      $display("FAIL %s done_latency: got %0d expected 2", tag, done_cyc - last_wr_cyc);
    end
    n_cmp++;
    if (busy !== 1'b0 || bus.res_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after: busy=%b ready=%b expected 0/0", tag, busy, bus.res_ready);
    end
    if (!rnd && stall == 0 && !restart) begin
      n_cmp++;
      if (last_acc_cyc - first_acc_cyc != n - 1) begin
        n_err++;
        $display("FAIL %s throughput: span %0d expected %0d", tag, last_acc_cyc - first_acc_cyc, n - 1);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.res_ready !== 1'b0 || bus.osif_write !== 1'b0 ||
        bus.osif_data_din !== 64'h0 || bus.osif_strb_din !== 8'h0 || bus.osif_last_din !== 1'b0 ||
        bus.osif_user_din !== 1'b0) begin
      n_err++;
      $display("FAIL %s outputs: busy=%b done=%b ready=%b write=%b data=%h strb=%h last=%b user=%b required all 0",
               tag, busy, done, bus.res_ready, bus.osif_write, bus.osif_data_din,
               bus.osif_strb_din, bus.osif_last_din, bus.osif_user_din);
    end
  endtask

  task automatic test_reset();
    bus.res_valid = 1'b0;
    bus.res_data = '0;
    bus.osif_full_n = 1'b1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_all_zero("reset");
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check_all_zero("after_reset_idle");
  endtask

  task automatic test_frame4();
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run_frame("frame4", 4, 0, 0, 0);
  endtask

  task automatic test_frame3();
    fill_random(3);
    run_frame("frame3", 3, 0, 0, 0);
  endtask

  task automatic test_zero_len();
    clear_obs();
    @(posedge aclk); #1;
    start = 1'b1;
    cfg_words = 16'd0;
    @(posedge aclk); #1;
    start = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.res_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len done_cycle: done=%b busy=%b ready=%b required 1/0/0", done, busy, bus.res_ready);
    end
    @(negedge aclk);
    @(negedge aclk);
    n_cmp++;
    if (done !== 1'b0 || done_cnt != 1 || obs.size() != 0) begin
      n_err++;
      $display("FAIL zero_len after: done=%b pulses=%0d writes=%0d required 0/1/0", done, done_cnt, obs.size());
    end
  endtask

  task automatic test_backpressure();
    fill_random(8);
    run_frame("backpressure", 8, 10, 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    int guard = 0;
    fill_random(6);
    clear_obs();
    @(posedge aclk); #1;
    start = 1'b1;
    cfg_words = 16'd6;
    @(posedge aclk); #1;
    start = 1'b0;
    bus.osif_full_n = 1'b0;
    while (acc_cnt < 3 && guard < 50) begin
      bus.res_valid = 1'b1;
      bus.res_data = words[acc_cnt];
      @(posedge aclk); #1;
      guard++;
    end
    n_cmp++;
    if (acc_cnt != 3) begin
      n_err++;
      $display("FAIL reset_mid setup: accepted %0d expected 3", acc_cnt);
    end
    #2;
    aresetn = 1'b0;
    #1;
    check_all_zero("reset_mid_async");
    bus.res_valid = 1'b0;
    bus.osif_full_n = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    n_cmp++;
    if (done_cnt != 0 || obs.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid leftovers: done=%0d writes=%0d required 0/0", done_cnt, obs.size());
    end
    fill_random(2);
    run_frame("after_reset", 2, 0, 0, 0);
  endtask

  task automatic test_restart_ignored();
    fill_random(4);
    run_frame("restart", 4, 0, 0, 1);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(1, 11);
      fill_random(n);
      run_frame($sformatf("random%0d", f), n, 0, 1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_frame4();
    test_frame3();
    test_zero_len();
    test_backpressure();
    test_reset_mid_frame();
    test_restart_ignored();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
